// File: rtl/masked_xor_sequencer.sv
// -----------------------------------------------------------------------------
// masked_xor_sequencer
//
// Purpose:
//   Sequences single operations through one external, registered, 2-share
//   masked XOR gate. Operand shares arrive over a valid/ready handshake. Each
//   accepted op draws three fresh mask bits from an internal Galois LFSR, and
//   the LFSR advances exactly once per accepted op, so mask material is never
//   reused. The block drives the gate for one cycle, captures the gate's
//   registered result and returns it over a valid/ready handshake.
//
// Ports:
//   clk, rst_n            clock (posedge) / asynchronous active-low reset
//   seed_valid, seed      LFSR reseed request (honoured only in IDLE)
//   in_valid, in_ready    operand handshake (in_ready high only in IDLE)
//   a0, a1, b0, b1        operand shares
//   out_valid, out_ready  result handshake (out_valid high only in OUT)
//   y0, y1                result shares, held until the next SAMPLE
//   g_a0..g_b1            registered operand drive to the gate
//   g_r0..g_r2            registered mask drive to the gate
//   g_y0, g_y1            gate outputs (registered inside the gate)
//   busy                  high whenever the sequencer is not IDLE
//   op_count              completed output handshakes, saturating
// -----------------------------------------------------------------------------
module masked_xor_sequencer #(
  parameter int                LFSR_W       = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS    = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED_DEFAULT = 16'hACE1,
  parameter int                CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seed_valid,
  input  logic [LFSR_W-1:0] seed,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              a0,
  input  logic              a1,
  input  logic              b0,
  input  logic              b1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              y0,
  output logic              y1,
  output logic              g_a0,
  output logic              g_a1,
  output logic              g_b0,
  output logic              g_b1,
  output logic              g_r0,
  output logic              g_r1,
  output logic              g_r2,
  input  logic              g_y0,
  input  logic              g_y1,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_OUT    = 2'd3
  } state_t;

  // One Galois step, right-shift form: shift out the lsb and fold the taps
  // back in whenever the bit shifted out was a one.
  function automatic logic [LFSR_W-1:0] f_lfsr_step(input logic [LFSR_W-1:0] s);
    logic [LFSR_W-1:0] n;
    n = s >> 1;
    if (s[0]) begin
      n = n ^ LFSR_TAPS;
    end
    return n;
  endfunction

  // Reseeding with zero would lock the LFSR, so zero maps to the default seed.
  function automatic logic [LFSR_W-1:0] f_seed_fix(input logic [LFSR_W-1:0] s);
    return (s == '0) ? SEED_DEFAULT : s;
  endfunction

  // Saturating increment of the completed-op counter.
  function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  state_t              r_state;
  state_t              w_state_nxt;

  logic [LFSR_W-1:0]   r_lfsr;
  logic [LFSR_W-1:0]   w_lfsr_adv;
  logic [2:0]          w_mask;

  logic                r_g_a0, r_g_a1, r_g_b0, r_g_b1;
  logic                r_g_r0, r_g_r1, r_g_r2;
  logic                r_y0, r_y1;
  logic [CNT_W-1:0]    r_op_count;

  logic                w_in_ready;
  logic                w_out_valid;
  logic                w_busy;

  logic                w_idle;
  logic                w_reseed;
  logic                w_accept;
  logic                w_release;

  // Handshake qualifiers. A reseed request in IDLE wins over an operand
  // request in the same cycle, so the operand is simply not accepted.
  assign w_idle    = (r_state == ST_IDLE);
  assign w_reseed  = w_idle && seed_valid;
  assign w_accept  = w_idle && in_valid && !seed_valid;
  assign w_release = (r_state == ST_OUT) && out_ready;

  // Masks come from the state before advancing; the three steps are unrolled
  // so one op consumes exactly three fresh bits in a single cycle.
  assign w_mask     = r_lfsr[2:0];
  assign w_lfsr_adv = f_lfsr_step(f_lfsr_step(f_lfsr_step(r_lfsr)));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_accept)  w_state_nxt = ST_DRIVE;
      ST_DRIVE:                 w_state_nxt = ST_SAMPLE;
      ST_SAMPLE:                w_state_nxt = ST_OUT;
      ST_OUT:    if (w_release) w_state_nxt = ST_IDLE;
      default:                  w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state-decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b1;
    unique case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b0;
      end
      ST_OUT: begin
        w_out_valid = 1'b1;
      end
      default: begin
        w_busy = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // LFSR: reseed or advance, only in IDLE
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= SEED_DEFAULT;
    end else if (w_reseed) begin
      r_lfsr <= f_seed_fix(seed);
    end else if (w_accept) begin
      r_lfsr <= w_lfsr_adv;
    end
  end

  // ---------------------------------------------------------------------------
  // Gate drive: operands and masks are loaded together on accept, held through
  // DRIVE (the gate captures at the end of DRIVE) and cleared together at the
  // end of SAMPLE, so operands never sit on the gate next to stale masks.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_g_a0 <= 1'b0;
      r_g_a1 <= 1'b0;
      r_g_b0 <= 1'b0;
      r_g_b1 <= 1'b0;
      r_g_r0 <= 1'b0;
      r_g_r1 <= 1'b0;
      r_g_r2 <= 1'b0;
    end else if (w_accept) begin
      r_g_a0 <= a0;
      r_g_a1 <= a1;
      r_g_b0 <= b0;
      r_g_b1 <= b1;
      r_g_r0 <= w_mask[0];
      r_g_r1 <= w_mask[1];
      r_g_r2 <= w_mask[2];
    end else if (r_state == ST_SAMPLE) begin
      r_g_a0 <= 1'b0;
      r_g_a1 <= 1'b0;
      r_g_b0 <= 1'b0;
      r_g_b1 <= 1'b0;
      r_g_r0 <= 1'b0;
      r_g_r1 <= 1'b0;
      r_g_r2 <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Result capture: the gate's registered output is valid during SAMPLE.
  // The shares persist after OUT until the next op reaches SAMPLE.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y0 <= 1'b0;
      r_y1 <= 1'b0;
    end else if (r_state == ST_SAMPLE) begin
      r_y0 <= g_y0;
      r_y1 <= g_y1;
    end
  end

  // ---------------------------------------------------------------------------
  // Completed-op counter, bumped on each output handshake
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_count <= '0;
    end else if (w_release) begin
      r_op_count <= f_sat_inc(r_op_count);
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign busy      = w_busy;
  assign y0        = r_y0;
  assign y1        = r_y1;
  assign g_a0      = r_g_a0;
  assign g_a1      = r_g_a1;
  assign g_b0      = r_g_b0;
  assign g_b1      = r_g_b1;
  assign g_r0      = r_g_r0;
  assign g_r1      = r_g_r1;
  assign g_r2      = r_g_r2;
  assign op_count  = r_op_count;

endmodule

// File: tb/tb_masked_xor_sequencer.sv
// -----------------------------------------------------------------------------
// tb_masked_xor_sequencer
//
// Bench for masked_xor_sequencer. A second instance with a 2-bit counter
// shares all stimulus so counter saturation can be observed alongside the
// main instance. Each instance gets its own behavioural registered gate.
// -----------------------------------------------------------------------------
module tb_masked_xor_sequencer;

  logic        clk;
  logic        rst_n;
  logic        seed_valid;
  logic [15:0] seed;
  logic        in_valid;
  logic        a0, a1, b0, b1;
  logic        out_ready;

  logic        in_ready, out_valid, y0, y1, busy;
  logic        g_a0, g_a1, g_b0, g_b1, g_r0, g_r1, g_r2;
  logic        g_y0 = 1'b0;
  logic        g_y1 = 1'b0;
  logic [15:0] op_count;

  logic        in_ready2, out_valid2, y0_2, y1_2, busy2;
  logic        g2_a0, g2_a1, g2_b0, g2_b1, g2_r0, g2_r1, g2_r2;
  logic        g2_y0 = 1'b0;
  logic        g2_y1 = 1'b0;
  logic [1:0]  op_count2;

  masked_xor_sequencer dut (
    .clk(clk), .rst_n(rst_n), .seed_valid(seed_valid), .seed(seed),
    .in_valid(in_valid), .in_ready(in_ready),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .out_valid(out_valid), .out_ready(out_ready), .y0(y0), .y1(y1),
    .g_a0(g_a0), .g_a1(g_a1), .g_b0(g_b0), .g_b1(g_b1),
    .g_r0(g_r0), .g_r1(g_r1), .g_r2(g_r2),
    .g_y0(g_y0), .g_y1(g_y1), .busy(busy), .op_count(op_count)
  );

  masked_xor_sequencer #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .seed_valid(seed_valid), .seed(seed),
    .in_valid(in_valid), .in_ready(in_ready2),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .out_valid(out_valid2), .out_ready(out_ready), .y0(y0_2), .y1(y1_2),
    .g_a0(g2_a0), .g_a1(g2_a1), .g_b0(g2_b0), .g_b1(g2_b1),
    .g_r0(g2_r0), .g_r1(g2_r1), .g_r2(g2_r2),
    .g_y0(g2_y0), .g_y1(g2_y1), .busy(busy2), .op_count(op_count2)
  );

  // Behavioural masked XOR gate: share-wise XOR refreshed with mask bits that
  // cancel in the recombined value, registered once.
  always @(posedge clk) begin
    g_y0  <= g_a0 ^ g_b0 ^ g_r0 ^ g_r1 ^ g_r2;
    g_y1  <= g_a1 ^ g_b1 ^ g_r0 ^ g_r1 ^ g_r2;
    g2_y0 <= g2_a0 ^ g2_b0 ^ g2_r0 ^ g2_r1 ^ g2_r2;
    g2_y1 <= g2_a1 ^ g2_b1 ^ g2_r0 ^ g2_r1 ^ g2_r2;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [15:0] m_lfsr;
  int          m_count;
  bit          used [logic [15:0]];

  typedef struct {
    logic       a0, a1, b0, b1;
    logic [2:0] exp_mask;
    logic       exp_par;
    logic [15:0] exp_lfsr;
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Three applications of the shift/feedback rule, written as plain arithmetic.
  function automatic logic [15:0] m_advance(input logic [15:0] s);
    logic [15:0] v;
    v = s;
    for (int k = 0; k < 3; k++) begin
      if (v[0]) v = (v >> 1) ^ 16'hB400;
      else      v = v >> 1;
    end
    return v;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_lfsr  = 16'hACE1;
    m_count = 0;
    used.delete();
  endtask

  // One complete operation with optional backpressure in OUT.
  task automatic run_op(input logic a0_i, input logic a1_i, input logic b0_i,
                        input logic b1_i, input int stall, input logic seed_in_out,
                        output logic [2:0] mask_o);
    int  n;
    logic [1:0] yh;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    a0 = a0_i; a1 = a1_i; b0 = b0_i; b1 = b1_i;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    // cycle 1: DRIVE
    chk("drive_busy", {31'd0, busy}, 32'd1);
    chk("drive_in_ready", {31'd0, in_ready}, 32'd0);
    chk("drive_out_valid", {31'd0, out_valid}, 32'd0);
    chk("drive_g_ops", {28'd0, g_a0, g_a1, g_b0, g_b1}, {28'd0, a0_i, a1_i, b0_i, b1_i});
    mask_o = {g_r2, g_r1, g_r0};
    chk("drive_mask", {29'd0, mask_o}, {29'd0, m_lfsr[2:0]});
    chk("lfsr_state_fresh", {31'd0, used.exists(m_lfsr) ? 1'b1 : 1'b0}, 32'd0);
    used[m_lfsr] = 1'b1;
    m_lfsr = m_advance(m_lfsr);
    chk("lfsr_advance", {16'd0, dut.r_lfsr}, {16'd0, m_lfsr});
    tick();
    // cycle 2: SAMPLE
    chk("sample_out_valid", {31'd0, out_valid}, 32'd0);
    chk("sample_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    // cycle 3: OUT
    chk("out_valid", {31'd0, out_valid}, 32'd1);
    chk("xor_invariant", {31'd0, y0 ^ y1}, {31'd0, a0_i ^ a1_i ^ b0_i ^ b1_i});
    chk("out_g_clear", {25'd0, g_a0, g_a1, g_b0, g_b1, g_r0, g_r1, g_r2}, 32'd0);
    yh = {y0, y1};
    for (int s = 0; s < stall; s++) begin
      seed_valid = seed_in_out;
      seed = 16'h5A5A;
      tick();
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_y", {30'd0, y0, y1}, {30'd0, yh});
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_lfsr", {16'd0, dut.r_lfsr}, {16'd0, m_lfsr});
    end
    seed_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    m_count++;
    chk("post_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_out_valid", {31'd0, out_valid}, 32'd0);
    chk("post_y_hold", {30'd0, y0, y1}, {30'd0, yh});
    chk("op_count", {16'd0, op_count}, sat(m_count, 65535));
    chk("op_count_sat2", {30'd0, op_count2}, sat(m_count, 3));
  endtask

  initial begin
    logic [2:0] msk;

    tbl[0] = '{a0: 1'b1, a1: 1'b0, b0: 1'b1, b1: 1'b1, exp_mask: 3'b001, exp_par: 1'b1, exp_lfsr: 16'h389C};
    tbl[1] = '{a0: 1'b0, a1: 1'b1, b0: 1'b1, b1: 1'b0, exp_mask: 3'b100, exp_par: 1'b0, exp_lfsr: 16'hB313};
    tbl[2] = '{a0: 1'b1, a1: 1'b1, b0: 1'b0, b1: 1'b1, exp_mask: 3'b011, exp_par: 1'b1, exp_lfsr: 16'h6162};
    tbl[3] = '{a0: 1'b0, a1: 1'b0, b0: 1'b0, b1: 1'b0, exp_mask: 3'b010, exp_par: 1'b0, exp_lfsr: 16'h562C};

    rst_n = 1'b0; seed_valid = 1'b0; seed = 16'd0; in_valid = 1'b0;
    a0 = 1'b0; a1 = 1'b0; b0 = 1'b0; b1 = 1'b0; out_ready = 1'b0;
    model_reset();
    #2;
    chk("rst_outputs", {22'd0, out_valid, busy, y0, y1, g_a0, g_a1, g_b0, g_b1, g_r0, g_r1}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_op_count", {16'd0, op_count}, 32'd0);
    chk("rst_lfsr", {16'd0, dut.r_lfsr}, 32'h0000ACE1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_g_r2", {31'd0, g_r2}, 32'd0);

    // Table-driven back-to-back ops from the reset seed
    for (int i = 0; i < 4; i++) begin
      run_op(tbl[i].a0, tbl[i].a1, tbl[i].b0, tbl[i].b1, 0, 1'b0, msk);
      chk($sformatf("tbl%0d_mask", i), {29'd0, msk}, {29'd0, tbl[i].exp_mask});
      chk($sformatf("tbl%0d_lfsr", i), {16'd0, dut.r_lfsr}, {16'd0, tbl[i].exp_lfsr});
      chk($sformatf("tbl%0d_par", i), {31'd0, y0 ^ y1}, {31'd0, tbl[i].exp_par});
    end
    chk("tbl_op_count", {16'd0, op_count}, 32'd4);

    // Backpressure for 5 cycles with a reseed attempt during OUT
    run_op(1'b1, 1'b0, 1'b0, 1'b0, 5, 1'b1, msk);
    chk("bp_lfsr_unchanged", {16'd0, dut.r_lfsr}, {16'd0, m_advance(16'h562C)});
    chk("sat_after_5", {30'd0, op_count2}, 32'd3);

    // Zero reseed collides with in_valid: reseed wins, no op accepted
    seed_valid = 1'b1; seed = 16'd0; in_valid = 1'b1; a0 = 1'b1;
    tick();
    seed_valid = 1'b0; in_valid = 1'b0;
    chk("reseed_zero_lfsr", {16'd0, dut.r_lfsr}, 32'h0000ACE1);
    chk("reseed_no_accept", {31'd0, busy}, 32'd0);
    chk("reseed_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("reseed_still_idle", {31'd0, busy}, 32'd0);
    m_lfsr = 16'hACE1;
    used.delete();
    seed_valid = 1'b1; seed = 16'h1234;
    tick();
    seed_valid = 1'b0;
    chk("reseed_value", {16'd0, dut.r_lfsr}, 32'h00001234);
    m_lfsr = 16'h1234;
    run_op(1'b0, 1'b1, 1'b1, 1'b1, 1, 1'b0, msk);
    chk("reseed_mask", {29'd0, msk}, 32'd4);

    // Asynchronous reset in the middle of DRIVE
    a0 = 1'b1; a1 = 1'b1; b0 = 1'b1; b1 = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("mid_drive_busy", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_g", {25'd0, g_a0, g_a1, g_b0, g_b1, g_r0, g_r1, g_r2}, 32'd0);
    chk("mid_rst_outs", {28'd0, out_valid, busy, y0, y1}, 32'd0);
    chk("mid_rst_op_count", {16'd0, op_count}, 32'd0);
    chk("mid_rst_lfsr", {16'd0, dut.r_lfsr}, 32'h0000ACE1);
    tick(); tick();
    rst_n = 1'b1;
    model_reset();
    tick();
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_count2", {30'd0, op_count2}, 32'd0);

    // Randomized ops against the model
    for (int i = 0; i < 1000; i++) begin
      logic [3:0] ops;
      int gap;
      ops = 4'($urandom);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        tick();
      end
      run_op(ops[0], ops[1], ops[2], ops[3], $urandom_range(0, 3), 1'($urandom), msk);
    end
    chk("rand_op_count", {16'd0, op_count}, 32'd1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
